bcd_sub_serial: RTL and testbench

BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_digit_sub.sv | 18 +
 rtl/bcd_sub_serial.sv | 113 +++++++++++
 tb/tb_bcd_sub_serial.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state encoding, BCD radix and digit-validity helper
// for the serial BCD subtractor.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
  localparam logic [3:0] BCD_RADIX = 4'd10;
  function automatic logic digit_bad(input logic [3:0] x);
    return x >= BCD_RADIX;
  endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one-digit BCD subtract x-y-bi, yielding a digit 0..9 and
// a borrow-out.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);
  logic [4:0] w_t;
  always_comb begin
    w_t = {1'b0, x} - {1'b0, y} - {4'b0, bi};
    bo  = w_t[4];
    d   = bo ? w_t[3:0] + BCD_RADIX : w_t[3:0];
  end
endmodule

// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial BCD subtractor giving sign and magnitude of a-b-bin.
// Define BCD_DIGIT_CHECK_EN to flag operands containing digits above 9 via err.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              bin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              neg,
  output logic              err
);
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  state_t            r_state;
  logic [4*NDIG-1:0] r_a, r_b, r_result;
  logic [KW-1:0]     r_k;
  logic              r_borrow, r_busy, r_done, r_neg, r_err;
  logic [3:0]        w_x, w_y, w_d;
  logic              w_bo, w_bad, w_last;
`ifdef BCD_DIGIT_CHECK_EN
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      w_bad = w_bad | digit_bad(a[4*i +: 4]) | digit_bad(b[4*i +: 4]);
  end
`else
  assign w_bad = 1'b0;
`endif
  // FIX reuses the digit subtractor to form 0 - result, the ten's complement
  always_comb begin
    w_x    = r_state == FIX ? 4'd0 : r_a[4*r_k +: 4];
    w_y    = r_state == FIX ? r_result[4*r_k +: 4] : r_b[4*r_k +: 4];
    w_last = r_k == KW'(NDIG - 1);
  end
  bcd_digit_sub u_dig (
    .x (w_x),
    .y (w_y),
    .bi(r_borrow),
    .d (w_d),
    .bo(w_bo)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_k      <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a      <= a;
          r_b      <= b;
          r_borrow <= bin;
          r_result <= '0;
          r_neg    <= 1'b0;
          r_err    <= w_bad;
          r_k      <= '0;
          r_busy   <= 1'b1;
          r_state  <= SUB;
        end
        SUB: if (r_err) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_result[4*r_k +: 4] <= w_d;
          r_borrow             <= w_bo;
          r_k                  <= r_k + KW'(1);
          if (w_last && w_bo) begin
            r_neg    <= 1'b1;
            r_k      <= '0;
            r_borrow <= 1'b0;
            r_state  <= FIX;
          end else if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        FIX: begin
          r_result[4*r_k +: 4] <= w_d;
          r_borrow             <= w_bo;
          r_k                  <= r_k + KW'(1);
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign neg    = r_neg;
  assign err    = r_err;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial: directed-vector bench with an integer-arithmetic model of
// a-b-bin; a negedge compare process checks every done pulse against it.
module tb_bcd_sub_serial;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [4*N-1:0] a = '0, b = '0;
  logic busy, done, neg, err;
  logic [4*N-1:0] result;
  int n_tests = 0, n_fail = 0, t_edges = 0, acc_edge = 0;
  logic expecting = 1'b0, err_only = 1'b0, exp_neg = 1'b0, exp_err = 1'b0;
  logic [4*N-1:0] exp_res = '0;
  int exp_lat = 0;

  bcd_sub_serial #(.NDIG(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .result(result), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) t_edges++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [4*N-1:0] x, input logic [4*N-1:0] y,
                                input logic bi, output logic [4*N-1:0] r, output logic n);
    int vx = 0, vy = 0, d;
    for (int i = N - 1; i >= 0; i--) begin
      vx = vx * 10 + int'(x[4*i +: 4]);
      vy = vy * 10 + int'(y[4*i +: 4]);
    end
    d = vx - vy - int'(bi);
    n = d < 0;
    if (n) d = -d;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (!expecting) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        if (!err_only) begin
          chk("result", 32'(result), 32'(exp_res));
          chk("neg", 32'(neg), 32'(exp_neg));
          chk("latency", 32'(t_edges - acc_edge + 1), 32'(exp_lat));
        end
        chk("err", 32'(err), 32'(exp_err));
        chk("busy_in_done", 32'(busy), 32'd1);
        expecting = 1'b0;
      end
    end
  end

  task automatic wait_done();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 40) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic launch(input logic [4*N-1:0] x, input logic [4*N-1:0] y, input logic bi);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
    a = x; b = y; bin = bi; start = 1'b1;
    acc_edge = t_edges + 1;
  endtask

  task automatic op(input logic [4*N-1:0] x, input logic [4*N-1:0] y, input logic bi,
                    input logic [4*N-1:0] lit_r, input logic lit_n, input logic poke);
    logic [4*N-1:0] r;
    logic n;
    model(x, y, bi, r, n);
    chk("model_pin", {15'd0, n, r}, {15'd0, lit_n, lit_r});
    launch(x, y, bi);
    exp_res = r; exp_neg = n; exp_err = 1'b0; err_only = 1'b0;
    exp_lat = n ? 2 * N + 1 : N + 1;
    expecting = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h4444; b = 16'h3333; bin = ~bi;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (poke) begin
      @(negedge clk);
      start = 1'b1; a = 16'h9999; b = 16'h0000;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        bi;
    logic [15:0] r;
    logic        n;
  } vec_t;
  vec_t vecs[10] = '{
    '{16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0},
    '{16'h0567, 16'h1234, 1'b0, 16'h0667, 1'b1},
    '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1},
    '{16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0},
    '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0},
    '{16'h0100, 16'h0001, 1'b1, 16'h0098, 1'b0},
    '{16'h5000, 16'h5000, 1'b1, 16'h0001, 1'b1},
    '{16'h0001, 16'h9999, 1'b0, 16'h9998, 1'b1},
    '{16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0},
    '{16'h4321, 16'h1234, 1'b1, 16'h3086, 1'b0}
  };

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    foreach (vecs[i]) op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].r, vecs[i].n, i == 0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_result", 32'(result), 32'(exp_res));
      chk("hold_neg", 32'(neg), 32'(exp_neg));
      chk("hold_busy", 32'(busy), 32'd0);
    end
    launch(16'h00A0, 16'h0000, 1'b0);
`ifdef BCD_DIGIT_CHECK_EN
    exp_err = 1'b1; exp_res = '0; exp_neg = 1'b0; exp_lat = 2; err_only = 1'b0;
`else
    exp_err = 1'b0; err_only = 1'b1;
`endif
    expecting = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    launch(16'h1234, 16'h0567, 1'b0);
    expecting = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_neg", 32'(neg), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_restart_busy", 32'(busy), 32'd0);
    op(16'h0567, 16'h1234, 1'b0, 16'h0667, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
